// File: rtl/down_counter.sv
// down_counter: loadable down-counter with a three-state IDLE/RUN/DONE controller.
// q, borrow, zero and busy are all registered and update on the same edge.
// Optional macro DOWN_COUNTER_RELOAD_EN: remembers the last loaded value and
// restarts the count from it when en is seen in DONE (free-running period).
//
//   state | meaning
//   IDLE  | after clear; q held, en ignored
//   RUN   | counting down, one step per enabled cycle
//   DONE  | count reached zero; waits for load (or reload when enabled)
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] q_nx;
    logic             borrow_nx;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload;

    // Reload value follows every load so DONE can restart the same period.
    always_ff @(posedge clk) begin
        if (clear) begin
            reload <= '0;
        end else if (load) begin
            reload <= load_val;
        end
    end
`endif

    // State and output registers; clear wins over everything else.
    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            q      <= '0;
            borrow <= 1'b0;
            zero   <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            q      <= q_nx;
            borrow <= borrow_nx;
            zero   <= (q_nx == '0);
            busy   <= (state_nx == RUN);
        end
    end

    // Next-state and next-count decode; load has priority over en.
    always_comb begin
        state_nx  = state;
        q_nx      = q;
        borrow_nx = 1'b0;
        if (load) begin
            q_nx = load_val;
            if (load_val != '0) begin
                state_nx = RUN;
            end else begin
                state_nx  = DONE;
                borrow_nx = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        // q <= 1 folds the (unreachable) q == 0 case into the
                        // terminal step so the count can never wrap.
                        if (q > WIDTH'(1)) begin
                            q_nx = q - WIDTH'(1);
                        end else begin
                            q_nx      = '0;
                            state_nx  = DONE;
                            borrow_nx = 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef DOWN_COUNTER_RELOAD_EN
                    if (en && (reload != '0)) begin
                        q_nx     = reload;
                        state_nx = RUN;
                    end
`else
                    q_nx = '0;
`endif
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed scenarios plus random stimulus, checked against a
// behavioural model of the counter kept as plain integers.
module tb_down_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clear, load, en;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             borrow, zero, busy;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int m_q, m_rel;
    bit m_run, m_done, m_b;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q),
        .borrow   (borrow),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit c, input bit l, input int v, input bit e);
        m_b = 1'b0;
        if (c) begin
            m_q = 0; m_rel = 0; m_run = 0; m_done = 0;
        end else if (l) begin
            m_q = v; m_rel = v;
            m_run = (v != 0); m_done = (v == 0); m_b = (v == 0);
        end else if (m_run && e) begin
            m_q = m_q - 1;
            if (m_q == 0) begin
                m_b = 1'b1; m_run = 0; m_done = 1;
            end
`ifdef DOWN_COUNTER_RELOAD_EN
        end else if (m_done && e && m_rel != 0) begin
            m_q = m_rel; m_run = 1; m_done = 0;
`endif
        end
    endfunction

    // one clock with the given inputs; model advanced and DUT compared after the edge
    task automatic step(input bit c, input bit l, input int v, input bit e);
        clear = c; load = l; load_val = WIDTH'(v); en = e;
        @(posedge clk);
        model(c, l, v, e);
        #1;
        chk("q", int'(q), m_q);
        chk("borrow", int'(borrow), int'(m_b));
        chk("zero", int'(zero), int'(m_q == 0));
        chk("busy", int'(busy), int'(m_run));
    endtask

    initial begin
        clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
        @(negedge clk);

        // clear for two cycles then release
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_q", int'(q), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_borrow", int'(borrow), 0);
        chk("rst_busy", int'(busy), 0);

        // load 3, count to zero
        step(0, 1, 3, 1);
        chk("ld3_q", int'(q), 3);
        chk("ld3_busy", int'(busy), 1);
        for (int i = 2; i >= 0; i--) begin
            step(0, 0, 0, 1);
            chk("cnt_q", int'(q), i);
            chk("cnt_borrow", int'(borrow), int'(i == 0));
            chk("cnt_busy", int'(busy), int'(i != 0));
        end
`ifndef DOWN_COUNTER_RELOAD_EN
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("hold0_q", int'(q), 0);
            chk("hold0_borrow", int'(borrow), 0);
        end
`endif

        // en toggling, then load overriding en
        step(0, 1, 5, 0);
        chk("tog_q0", int'(q), 5);
        step(0, 0, 0, 1); chk("tog_q1", int'(q), 4);
        step(0, 0, 0, 0); chk("tog_q2", int'(q), 4);
        step(0, 0, 0, 1); chk("tog_q3", int'(q), 3);
        step(0, 0, 0, 0); chk("tog_q4", int'(q), 3);
        step(0, 1, 9, 1); chk("ld_prio_q", int'(q), 9);

        // load of zero: immediate terminal event, twice in a row
        step(0, 1, 0, 0);
        chk("ld0_q", int'(q), 0);
        chk("ld0_borrow", int'(borrow), 1);
        chk("ld0_busy", int'(busy), 0);
        chk("ld0_zero", int'(zero), 1);
        step(0, 1, 0, 0);
        chk("ld0b_borrow", int'(borrow), 1);
        step(0, 0, 0, 0);
        chk("ld0_pulse_end", int'(borrow), 0);

        // clear mid-count
        step(0, 1, 15, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        chk("pre_clr_q", int'(q), 7);
        step(1, 1, 12, 1);
        chk("clr_q", int'(q), 0);
        chk("clr_borrow", int'(borrow), 0);
        chk("clr_busy", int'(busy), 0);
        step(0, 0, 0, 1); chk("idle_en_q", int'(q), 0);
        step(0, 0, 0, 1); chk("idle_en_busy", int'(busy), 0);

`ifdef DOWN_COUNTER_RELOAD_EN
        // free-running reload with period 3
        step(0, 1, 2, 1);
        chk("rl_q0", int'(q), 2);
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 0, 1);
            chk("rl_q", int'(q), 2 - (i % 3));
            chk("rl_borrow", int'(borrow), int'((i % 3) == 2));
        end
`endif

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, count register width in bits (legal range 2..16).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port clear  input  1  reset; synchronous and active-high.
REQ-004 SHALL provide port load  input  1  load strobe; captures load_val.
REQ-005 SHALL provide port load_val  input  WIDTH  start value of the count.
REQ-006 SHALL provide port en  input  1  count enable; one decrement per enabled cycle.
REQ-007 SHALL provide port q  output  WIDTH  current count, registered.
REQ-008 SHALL provide port borrow  output  1  registered one-cycle pulse on reaching zero.
REQ-009 SHALL provide port zero  output  1  registered, high whenever q == 0.
REQ-010 SHALL provide port busy  output  1  registered, high while in RUN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE: q holds its value; en is ignored.
REQ-013 Any state, load=1: q <= load_val on the next edge; state <= RUN if load_val != 0; state <= DONE with borrow=1 if load_val == 0.
REQ-014 load SHALL take priority over en in the same cycle; no decrement occurs in the load cycle.
REQ-015 RUN, en=1, q > 1: q <= q - 1; remain in RUN.
REQ-016 RUN, en=1, q == 1: q <= 0; state <= DONE; borrow <= 1 for exactly that one cycle.
REQ-017 RUN, en=0: q and state hold.
REQ-018 DONE: q stays 0 and borrow returns to 0 after one cycle; behaviour with en is set by REQ-026/REQ-027.
REQ-019 q SHALL never wrap from 0 to all-ones; a decrement below zero is impossible in every state.
REQ-020 borrow and zero SHALL update in the same edge as q (no extra latency).
REQ-021 borrow SHALL never be high in two consecutive cycles unless a new terminal event occurs in each cycle (e.g., consecutive loads of 0).

Reset
REQ-022 clear=1 on a rising edge: q <= 0, state <= IDLE, borrow <= 0, busy <= 0, zero <= 1.
REQ-023 clear SHALL take priority over load and en, including mid-count in RUN.
REQ-024 clear SHALL have no effect between clock edges.
REQ-025 On the first edge after clear deasserts, normal operation resumes from IDLE.

Configuration
REQ-026 Macro DOWN_COUNTER_RELOAD_EN defined:
  - an internal WIDTH-bit reload register captures load_val on every load and resets to 0 on clear.
  - DONE, en=1, reload register != 0: q <= reload register; state <= RUN. The result is a free-running period of (reload+1) enabled cycles.
  - DONE, en=1, reload register == 0: the block stays in DONE.
REQ-027 Macro DOWN_COUNTER_RELOAD_EN undefined:
  - no reload register is built.
  - DONE ignores en and leaves only on load or clear.

Verification (WIDTH=4)
REQ-028 clear=1 for 2 cycles, then released -> q=0, zero=1, borrow=0, busy=0, state IDLE.
REQ-029 load=1, load_val=3, then en=1 continuously:
  - q sequence 3,2,1,0.
  - borrow=1 only in the cycle where q=0.
  - busy falls with q=0.
  - q then stays 0 (macro undefined).
REQ-030 load_val=5, en toggling 1,0,1,0 -> q sequence 5,4,4,3,3; load_val=9 with en=1 in the same cycle -> q=9, not 8.
REQ-031 load_val=0 -> next edge q=0, borrow=1 for one cycle, busy=0, zero=1.
REQ-032 load_val=15, en=1, clear=1 asserted when q=7 -> next edge q=0, IDLE, borrow=0; then en=1 alone -> q stays 0.
REQ-033 Macro defined, load_val=2, en=1 for 9 cycles -> q sequence 2,1,0,2,1,0,2,1,0; borrow pulses in every cycle where q=0.
